// File: rtl/multu_unit_pkg.sv
// Shared execute-stage constants: ALU function codes, multiplier FSM states
// and the default operand width.
package multu_unit_pkg;

   localparam int MULTU_WIDTH = 32;

   localparam logic [5:0] FN_SRL   = 6'd2;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;
   localparam logic [5:0] FN_SLT   = 6'd42;
   localparam logic [5:0] FN_OUT   = 6'd63;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } multu_state_t;

endpackage

// File: rtl/multu_unit_step.sv
// One shift-add step of an unsigned multiply: conditionally add the
// multiplicand into the upper half, then shift the whole product right by one.
module multu_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] prod,
   input  logic [WIDTH-1:0]   mcand,
   output logic [2*WIDTH-1:0] prod_next
);

   logic [WIDTH:0] upper_sum;

   // The extra top bit keeps the carry so it shifts back into the product.
   always_comb begin
      upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (prod[0]) begin
         upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      end
      prod_next = {upper_sum, prod[WIDTH-1:1]};
   end

endmodule

// File: rtl/multu_unit.sv
// Sequential unsigned multiplier beside the ALU; steps one bit per clock while
// the control block holds MULTU and commits to HI/LO only on the OUT code.
module multu_unit
   import multu_unit_pkg::*;
#(
   parameter int         WIDTH     = MULTU_WIDTH,
   parameter logic [5:0] SEL_MULTU = FN_MULTU,
   parameter logic [5:0] SEL_OUT   = FN_OUT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       sel,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             ready
);

   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

   multu_state_t       state_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic [2*WIDTH-1:0] prod_next;
   logic [WIDTH-1:0]   mcand_reg;
   logic [SW-1:0]      step_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic               ready_reg;

   multu_step #(.WIDTH(WIDTH)) u_step (
      .prod      (prod_reg),
      .mcand     (mcand_reg),
      .prod_next (prod_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         prod_reg  <= '0;
         mcand_reg <= '0;
         step_reg  <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         busy_reg  <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (sel == SEL_MULTU) begin
                  mcand_reg <= dataA;
                  prod_reg  <= {{WIDTH{1'b0}}, dataB};
                  step_reg  <= '0;
                  state_reg <= ST_RUN;
                  busy_reg  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (sel == SEL_MULTU) begin
                  prod_reg <= prod_next;
                  if (step_reg == LAST_STEP) begin
                     state_reg <= ST_DONE;
                     busy_reg  <= 1'b0;
                     ready_reg <= 1'b1;
                  end else begin
                     step_reg <= step_reg + 1'b1;
                  end
               end else begin
                  // Anything but MULTU mid-run (OUT included) abandons the product.
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            ST_DONE: begin
               if (sel != SEL_MULTU) begin
                  if (sel == SEL_OUT) begin
                     hi_reg <= prod_reg[2*WIDTH-1:WIDTH];
                     lo_reg <= prod_reg[WIDTH-1:0];
                  end
                  state_reg <= ST_IDLE;
                  ready_reg <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               ready_reg <= 1'b0;
            end
         endcase
      end
   end

   assign hi    = hi_reg;
   assign lo    = lo_reg;
   assign busy  = busy_reg;
   assign ready = ready_reg;

endmodule

// File: tb/tb_multu_unit.sv
// Directed bench for multu_unit: load/step/commit sequences, abort, reset,
// stray OUT codes, operand changes after load and back-to-back operation.
module tb_multu_unit;
   import multu_unit_pkg::*;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic [5:0]   sel;
   logic [W-1:0] dataA;
   logic [W-1:0] dataB;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         ready;

   int n_cmp = 0;
   int n_err = 0;

   multu_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sel   (sel),
      .dataA (dataA),
      .dataB (dataB),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .ready (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load, 32 step edges, optional extra MULTU hold edges in DONE, then OUT.
   task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit scramble, input int hold,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      sel   = FN_MULTU;
      dataA = a;
      dataB = b;
      tick();
      for (int i = 0; i < W - 1; i++) begin
         if (scramble) begin
            dataA = $urandom;
            dataB = $urandom;
         end
         tick();
      end
      check({tag, " busy@32"}, 64'(busy), 64'd1);
      check({tag, " ready@32"}, 64'(ready), 64'd0);
      tick();
      check({tag, " ready@33"}, 64'(ready), 64'd1);
      check({tag, " busy@33"}, 64'(busy), 64'd0);
      for (int i = 0; i < hold; i++) tick();
      if (hold > 0) check({tag, " ready hold"}, 64'(ready), 64'd1);
      sel = FN_OUT;
      tick();
      check({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo), 64'(exp_lo));
      check({tag, " idle"}, {62'd0, busy, ready}, 64'd0);
   endtask

   initial begin
      int ready_seen;
      rst_n = 1'b0;
      sel   = FN_ADD;
      dataA = '0;
      dataB = '0;
      tick();
      tick();
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      check("reset busy/ready", {62'd0, busy, ready}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic 3*5, with a two-edge MULTU hold in DONE before committing.
      run_mul("basic", 32'd3, 32'd5, 1'b0, 2, 32'd0, 32'd15);
      sel = FN_ADD;
      tick();

      run_mul("maxcarry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'hFFFF_FFFE, 32'h0000_0001);
      sel = FN_ADD;
      tick();

      // Abort 7*9 after 10 step edges.
      ready_seen = 0;
      sel   = FN_MULTU;
      dataA = 32'd7;
      dataB = 32'd9;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ready) ready_seen++;
      end
      check("abort busy before", 64'(busy), 64'd1);
      sel = FN_ADD;
      tick();
      if (ready) ready_seen++;
      check("abort busy", 64'(busy), 64'd0);
      sel = FN_OUT;
      tick();
      if (ready) ready_seen++;
      sel = FN_ADD;
      tick();
      check("abort ready never", 64'(ready_seen), 64'd0);
      check("abort hi kept", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      check("abort lo kept", 64'(lo), 64'd1);

      // OUT during RUN also aborts without writing.
      sel = FN_MULTU;
      dataA = 32'd100;
      dataB = 32'd100;
      tick();
      repeat (5) tick();
      sel = FN_OUT;
      tick();
      check("run-out busy", 64'(busy), 64'd0);
      check("run-out lo kept", 64'(lo), 64'd1);
      sel = FN_ADD;
      tick();

      // Reset at step 20.
      sel = FN_MULTU;
      dataA = 32'd11;
      dataB = 32'd13;
      tick();
      repeat (20) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sel = FN_ADD;
      check("midreset hi", 64'(hi), 64'd0);
      check("midreset lo", 64'(lo), 64'd0);
      check("midreset busy/ready", {62'd0, busy, ready}, 64'd0);
      tick();
      run_mul("post-reset", 32'd2, 32'd2, 1'b0, 0, 32'd0, 32'd4);
      sel = FN_ADD;
      tick();

      // OUT while IDLE does not touch HI/LO.
      sel = FN_OUT;
      tick();
      tick();
      check("idle-out hi", 64'(hi), 64'd0);
      check("idle-out lo", 64'(lo), 64'd4);
      sel = FN_ADD;
      tick();

      run_mul("latched", 32'h1234_5678, 32'h10, 1'b1, 0, 32'd1, 32'h2345_6780);
      sel = FN_ADD;
      tick();

      // Back-to-back: second MULTU immediately after the commit edge.
      run_mul("b2b first", 32'd6, 32'd7, 1'b0, 0, 32'd0, 32'd42);
      run_mul("b2b second", 32'h8000_0000, 32'd4, 1'b0, 0, 32'd2, 32'd0);
      sel = FN_ADD;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
